sysid_boot_checker: RTL and testbench
=====================================

SYSID_BOOT_CHECKER -- requirements
Module: sysid_boot_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000, the system ID value the block expects to read.
REQ-002 Parameter EXPECTED_TS, default 32'd1363472126, the build timestamp value the block expects to read.
REQ-003 Parameter READ_LATENCY, default 1, range 0..3, the extra cycles the address is held before readdata is sampled.
REQ-004 Port clock, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: request to re-run the check; sampled only in DONE.
REQ-007 Port sysid_address, output, 1 bit: sysid slave word select (0 = ID, 1 = timestamp).
REQ-008 Port sysid_readdata, input, 32 bits: sysid slave read data (combinational).
REQ-009 Port busy, output, 1 bit: high in RD_ID, RD_TS and CMP.
REQ-010 Port done, output, 1 bit: high in DONE.
REQ-011 Port match, output, 1 bit: result of the last completed compare.
REQ-012 Port id_value, output, 32 bits: last captured ID word.
REQ-013 Port ts_value, output, 32 bits: last captured timestamp word.
REQ-014 Port mismatch_count, output, 8 bits: count of failed compares; saturates at 255.

Function
REQ-015 The state machine SHALL use the states IDLE, RD_ID, RD_TS, CMP and DONE.
REQ-016 IDLE SHALL go to RD_ID unconditionally on the first edge after reset is released.
REQ-017 RD_ID SHALL drive sysid_address=0 for READ_LATENCY+1 cycles, load id_value from sysid_readdata on the last of those cycles, then go to RD_TS.
REQ-018 RD_TS SHALL drive sysid_address=1 for READ_LATENCY+1 cycles, load ts_value on the last of those cycles, then go to CMP.
REQ-019 CMP SHALL last 1 cycle, load match=(id_value==EXPECTED_ID)&&(ts_value==EXPECTED_TS), increment mismatch_count (saturating) when match=0, then go to DONE.
REQ-020 With the TS check compiled in, done SHALL go high 2*READ_LATENCY+4 edges after reset is released.
REQ-021 In DONE, start=1 SHALL move to RD_ID on the next edge; done then drops and match, id_value and ts_value hold until they are overwritten.
REQ-022 start SHALL be ignored in IDLE, RD_ID, RD_TS and CMP; it is not queued.
REQ-023 If start is held high, each run SHALL end with exactly one DONE cycle before the next run begins.
REQ-024 The latency counter SHALL be 2 bits wide and SHALL clear on every state change.
REQ-025 sysid_address SHALL be 0 in every state other than RD_TS.

Reset
REQ-026 Asserting reset SHALL at once set the state to IDLE and clear busy, done, match, sysid_address, id_value, ts_value, mismatch_count and the latency counter to 0.
REQ-027 A reset asserted in the middle of a run SHALL abort that run with no partial update after release; the check then re-runs per REQ-016.

Configuration
REQ-028 Macro SYSID_CHECK_TS_EN defined: the block SHALL behave as described above.
REQ-029 Macro SYSID_CHECK_TS_EN undefined: RD_ID SHALL go straight to CMP, RD_TS SHALL be absent, ts_value SHALL stay 0, match SHALL be (id_value==EXPECTED_ID), and done SHALL rise READ_LATENCY+3 edges after reset release.

Structure
REQ-030 Package sysid_checker_pkg SHALL hold the state enum, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1 and the mismatch counter width (8).
REQ-031 The block SHALL have no sub-module; the latency counter and compare logic SHALL be inline.

Verification
REQ-032 READ_LATENCY=1, slave returns 0 at address 0 and 1363472126 at address 1, TS enabled -> done=1 at edge 6 after release, match=1, id_value=0, ts_value=1363472126, mismatch_count=0.
REQ-033 Slave returns 32'h1 at address 0 -> match=0, mismatch_count=1; after 3 start pulses given in DONE -> mismatch_count=4.
REQ-034 start pulsed while busy=1 in RD_TS -> no effect; exactly one DONE cycle; start pulsed in DONE -> busy=1 on the next edge.
REQ-035 reset asserted while in RD_TS -> all outputs 0 during reset; after release the run restarts and done rises at edge 6.
REQ-036 mismatch_count preloaded to 255 by 255 failing runs, then one more failing run -> stays 255.
REQ-037 SYSID_CHECK_TS_EN undefined, READ_LATENCY=0 -> sysid_address never 1, done rises at edge 3, ts_value=0, match follows the ID only.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// -----------------------------------------------------------------------------
// sysid_checker_pkg
//
// Shared definitions for the sysid boot checker:
//   - sysid_state_e  : checker state machine encoding
//   - SYSID_ADDR_ID  : sysid slave word select for the system ID word
//   - SYSID_ADDR_TS  : sysid slave word select for the build timestamp word
//   - MISMATCH_CNT_W : width of the saturating mismatch counter
// -----------------------------------------------------------------------------
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int unsigned MISMATCH_CNT_W = 8;

  // Saturating increment for the mismatch counter.
  function automatic logic [MISMATCH_CNT_W-1:0] sat_inc(input logic [MISMATCH_CNT_W-1:0] v);
    if (v == {MISMATCH_CNT_W{1'b1}}) begin
      return v;
    end
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/sysid_boot_checker.sv
// -----------------------------------------------------------------------------
// sysid_boot_checker
//
// After reset release, reads the system ID word (and, when compiled in, the
// build timestamp word) from a sysid slave, compares them against the
// expected values and reports the result. The check re-runs on request.
//
// Configuration macro:
//   SYSID_CHECK_TS_EN  defined   : read and compare the timestamp word too.
//                      undefined : ID-only check, ts_value stays 0.
//
// Parameters:
//   EXPECTED_ID   expected system ID word
//   EXPECTED_TS   expected build timestamp word
//   READ_LATENCY  extra cycles the address is held before readdata is sampled
//                 (0..3)
//
// Ports:
//   clock           single clock, rising edge
//   reset           asynchronous active-high reset
//   start           re-run request, honoured only in DONE
//   sysid_address   slave word select (0 = ID, 1 = timestamp)
//   sysid_readdata  slave read data (combinational from sysid_address)
//   busy            high while reading or comparing
//   done            high in DONE
//   match           result of the last completed compare
//   id_value        last captured ID word
//   ts_value        last captured timestamp word
//   mismatch_count  failed compares, saturating at 255
// -----------------------------------------------------------------------------
module sysid_boot_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'd1363472126,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      sysid_address,
  input  logic [31:0]               sysid_readdata,
  output logic                      busy,
  output logic                      done,
  output logic                      match,
  output logic [31:0]               id_value,
  output logic [31:0]               ts_value,
  output logic [MISMATCH_CNT_W-1:0] mismatch_count
);

  // Last latency-counter value of a read state; the word is sampled there.
  localparam logic [1:0] LatLast = 2'(READ_LATENCY);

  sysid_state_e              state_q, state_d;
  logic [1:0]                lat_q, lat_d;
  logic [31:0]               id_q;
  logic                      match_q;
  logic [MISMATCH_CNT_W-1:0] cnt_q;
  logic                      lat_last;
  logic                      hit;

  assign lat_last = (lat_q == LatLast);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = RD_ID;
      RD_ID: begin
        if (lat_last) begin
`ifdef SYSID_CHECK_TS_EN
          state_d = RD_TS;
`else
          state_d = CMP;
`endif
        end
      end
`ifdef SYSID_CHECK_TS_EN
      RD_TS: begin
        if (lat_last) begin
          state_d = CMP;
        end
      end
`endif
      CMP: state_d = DONE;
      DONE: begin
        if (start) begin
          state_d = RD_ID;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The latency counter only advances while holding an address, and clears
  // whenever the state changes so every read state starts from zero.
  always_comb begin
    lat_d = '0;
    if ((state_d == state_q) && ((state_q == RD_ID) || (state_q == RD_TS))) begin
      lat_d = lat_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare
  // ---------------------------------------------------------------------------
`ifdef SYSID_CHECK_TS_EN
  logic [31:0] ts_q;
  assign hit = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
`else
  assign hit = (id_q == EXPECTED_ID);
  // Timestamp is not checked in this build; keep the parameter referenced.
  logic unused_expected_ts;
  assign unused_expected_ts = ^EXPECTED_TS;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q <= '0;
    end else if ((state_q == RD_ID) && lat_last) begin
      id_q <= sysid_readdata;
    end
  end

`ifdef SYSID_CHECK_TS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else if ((state_q == RD_TS) && lat_last) begin
      ts_q <= sysid_readdata;
    end
  end
  assign ts_value = ts_q;
`else
  assign ts_value = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == CMP) begin
      match_q <= hit;
      if (!hit) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sysid_address  = (state_q == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy           = (state_q == RD_ID) || (state_q == RD_TS) || (state_q == CMP);
  assign done           = (state_q == DONE);
  assign match          = match_q;
  assign id_value       = id_q;
  assign mismatch_count = cnt_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// -----------------------------------------------------------------------------
// tb_sysid_boot_checker
//
// Two checkers (READ_LATENCY 0 and 1) share clock, reset, start and a sysid
// slave model. A run-timeline model per instance predicts every output each
// cycle; directed literal checks pin done latency, captured values and the
// mismatch counter. Honours SYSID_CHECK_TS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_sysid_boot_checker;

`ifdef SYSID_CHECK_TS_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  localparam logic [31:0] ExpId = 32'h0000_0000;
  localparam logic [31:0] ExpTs = 32'd1363472126;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] id_word = 32'h0;
  logic [31:0] ts_word = 32'd1363472126;

  logic [1:0]  addr, busy, done, match;
  logic [31:0] rdata [2];
  logic [31:0] idv   [2];
  logic [31:0] tsv   [2];
  logic [7:0]  cnt   [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign rdata[0] = addr[0] ? ts_word : id_word;
  assign rdata[1] = addr[1] ? ts_word : id_word;

  sysid_boot_checker #(
    .EXPECTED_ID (ExpId),
    .EXPECTED_TS (ExpTs),
    .READ_LATENCY(0)
  ) u_dut0 (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .sysid_address (addr[0]),
    .sysid_readdata(rdata[0]),
    .busy          (busy[0]),
    .done          (done[0]),
    .match         (match[0]),
    .id_value      (idv[0]),
    .ts_value      (tsv[0]),
    .mismatch_count(cnt[0])
  );

  sysid_boot_checker #(
    .EXPECTED_ID (ExpId),
    .EXPECTED_TS (ExpTs),
    .READ_LATENCY(1)
  ) u_dut1 (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .sysid_address (addr[1]),
    .sysid_readdata(rdata[1]),
    .busy          (busy[1]),
    .done          (done[1]),
    .match         (match[1]),
    .id_value      (idv[1]),
    .ts_value      (tsv[1]),
    .mismatch_count(cnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: t counts edges since the run began (0 = just out of reset). A run
  // reads ID for RL+1 edges, then TS for RL+1 edges (if enabled), compares
  // for one edge and sits in DONE at t == D until start restarts it at t = 1.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    localparam int RL = (gi == 0) ? 0 : 1;
    localparam int D  = TsEn ? (2 * RL + 4) : (RL + 3);

    int          t;
    logic [31:0] m_id, m_ts;
    logic        m_match;
    logic [7:0]  m_cnt;
    logic        m_hit;

    assign m_hit = (m_id == ExpId) && (!TsEn || (m_ts == ExpTs));

    always @(posedge clock or posedge reset) begin
      if (reset) begin
        t       <= 0;
        m_id    <= '0;
        m_ts    <= '0;
        m_match <= 1'b0;
        m_cnt   <= '0;
      end else begin
        if (t == D) begin
          if (start) t <= 1;
        end else begin
          t <= t + 1;
        end
        if (t == RL + 1) m_id <= id_word;
        if (TsEn && (t == 2 * RL + 2)) m_ts <= ts_word;
        if (t == D - 1) begin
          m_match <= m_hit;
          if (!m_hit && (m_cnt != 8'd255)) m_cnt <= m_cnt + 8'd1;
        end
      end
    end

    always @(negedge clock) begin
      chk($sformatf("dut%0d.busy", gi), 32'(busy[gi]), 32'((t >= 1) && (t < D)));
      chk($sformatf("dut%0d.done", gi), 32'(done[gi]), 32'(t == D));
      chk($sformatf("dut%0d.addr", gi), 32'(addr[gi]),
          32'(TsEn && (t >= RL + 2) && (t <= 2 * RL + 2)));
      chk($sformatf("dut%0d.match", gi), 32'(match[gi]), 32'(m_match));
      chk($sformatf("dut%0d.id_value", gi), idv[gi], m_id);
      chk($sformatf("dut%0d.ts_value", gi), tsv[gi], m_ts);
      chk($sformatf("dut%0d.mismatch_count", gi), 32'(cnt[gi]), 32'(m_cnt));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic count_done_edges(output int e0, output int e1);
    e0 = 0;
    e1 = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clock);
      #1;
      if (done[0] && (e0 == 0)) e0 = e;
      if (done[1] && (e1 == 0)) e1 = e;
    end
  endtask

  task automatic wait_both_done(input int budget);
    int n = 0;
    while ((done != 2'b11) && (n < budget)) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("wait_done_timeout", 32'(done), 32'h3);
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.dut%0d.busy", tag, i), 32'(busy[i]), 32'h0);
      chk($sformatf("%s.dut%0d.done", tag, i), 32'(done[i]), 32'h0);
      chk($sformatf("%s.dut%0d.addr", tag, i), 32'(addr[i]), 32'h0);
      chk($sformatf("%s.dut%0d.match", tag, i), 32'(match[i]), 32'h0);
      chk($sformatf("%s.dut%0d.id", tag, i), idv[i], 32'h0);
      chk($sformatf("%s.dut%0d.ts", tag, i), tsv[i], 32'h0);
      chk($sformatf("%s.dut%0d.cnt", tag, i), 32'(cnt[i]), 32'h0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int e0, e1;

    // Reset state.
    repeat (3) @(posedge clock);
    #2 check_all_zero("reset");

    // Power-on run with the expected slave contents.
    @(posedge clock);
    #1 reset = 1'b0;
    count_done_edges(e0, e1);
    chk("done_edge_rl0", 32'(e0), TsEn ? 32'd4 : 32'd3);
    chk("done_edge_rl1", 32'(e1), TsEn ? 32'd6 : 32'd4);
    chk("boot.match", 32'(match[1]), 32'h1);
    chk("boot.id", idv[1], 32'h0);
    chk("boot.ts", tsv[1], TsEn ? 32'd1363472126 : 32'd0);
    chk("boot.cnt", 32'(cnt[1]), 32'h0);

    // Re-run on a start pulse in DONE: busy on the next edge.
    pulse_start();
    chk("restart.busy", 32'(busy), 32'h3);
    chk("restart.done", 32'(done), 32'h0);
    wait_both_done(20);
    chk("restart.match", 32'(match[1]), 32'h1);

    // Wrong ID word: one failing run, then three more.
    id_word = 32'h1;
    pulse_start();
    wait_both_done(20);
    chk("bad_id.match", 32'(match[1]), 32'h0);
    chk("bad_id.id", idv[1], 32'h1);
    chk("bad_id.cnt", 32'(cnt[1]), 32'h1);
    repeat (3) begin
      pulse_start();
      wait_both_done(20);
    end
    chk("bad_id.cnt4_rl0", 32'(cnt[0]), 32'h4);
    chk("bad_id.cnt4_rl1", 32'(cnt[1]), 32'h4);

    // Start pulsed mid-run on the RL=1 instance is ignored.
    pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk("midrun_start.busy_rl1", 32'(busy[1]), 32'h1);
    wait_both_done(20);
    repeat (3) @(posedge clock);
    #1 chk("midrun_start.still_done_rl1", 32'(done[1]), 32'h1);

    // Reset in the middle of a run (RD_TS for RL=1 when TS is compiled in).
    pulse_start();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #2 check_all_zero("midrun_reset");
    @(posedge clock);
    #1 reset = 1'b0;
    count_done_edges(e0, e1);
    chk("rerun.done_edge_rl0", 32'(e0), TsEn ? 32'd4 : 32'd3);
    chk("rerun.done_edge_rl1", 32'(e1), TsEn ? 32'd6 : 32'd4);

    // Saturate the mismatch counter with start held high.
    @(posedge clock);
    #1 start = 1'b1;
    repeat (2000) @(posedge clock);
    #1 start = 1'b0;
    wait_both_done(20);
    chk("sat.cnt_rl0", 32'(cnt[0]), 32'd255);
    chk("sat.cnt_rl1", 32'(cnt[1]), 32'd255);
    pulse_start();
    wait_both_done(20);
    chk("sat.hold_rl1", 32'(cnt[1]), 32'd255);

    // Good ID with a wrong timestamp: only matters when TS is checked.
    id_word = 32'h0;
    ts_word = 32'hDEAD_BEEF;
    pulse_start();
    wait_both_done(20);
    chk("id_only.match_rl0", 32'(match[0]), TsEn ? 32'h0 : 32'h1);
    chk("id_only.ts_rl1", tsv[1], TsEn ? 32'hDEAD_BEEF : 32'h0);
    chk("id_only.cnt_rl1", 32'(cnt[1]), 32'd255);

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
